// File: rtl/aes_round_ctrl_if.sv
// Handshake and strobe bundle between the AES round controller and its
// surroundings (command interface upstream, round datapath downstream).
interface aes_round_ctrl_if;
   logic       i_start_valid;
   logic       o_start_ready;
   logic       o_state_load;
   logic       o_state_en;
   logic       o_key_en;
   logic [7:0] o_rcon;
   logic [3:0] o_round;
   logic       o_last_round;
   logic       o_busy;
   logic       o_out_valid;
   logic       i_out_ready;

   // Controller side
   modport master (
      input  i_start_valid,
      input  i_out_ready,
      output o_start_ready,
      output o_state_load,
      output o_state_en,
      output o_key_en,
      output o_rcon,
      output o_round,
      output o_last_round,
      output o_busy,
      output o_out_valid
   );

   // Environment side
   modport slave (
      output i_start_valid,
      output i_out_ready,
      input  o_start_ready,
      input  o_state_load,
      input  o_state_en,
      input  o_key_en,
      input  o_rcon,
      input  o_round,
      input  o_last_round,
      input  o_busy,
      input  o_out_valid
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: initial AddRoundKey, then NUM_ROUNDS rounds, each
// waiting SB_LATENCY cycles for sub_bytes before committing the round result
// and stepping the key schedule with the matching Rcon.
module aes_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned SB_LATENCY = 1
) (
   input logic              i_clk,
   input logic              i_rst_n,
   aes_round_ctrl_if.master ctrl_io
);

   localparam int unsigned     CntW      = (SB_LATENCY > 1) ? $clog2(SB_LATENCY) : 1;
   localparam logic [3:0]      LastRound = 4'(NUM_ROUNDS);
   localparam logic [CntW-1:0] WaitMax   = CntW'(SB_LATENCY - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StSub,
      StUpd,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      round_q, round_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [CntW-1:0] wait_q, wait_d;

   // GF(2^8) multiply by x, used to advance Rcon
   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   // State, round index, Rcon and sub_bytes wait counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         round_q <= '0;
         rcon_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state sequencing; Rcon advances on every key-enable cycle
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl_io.i_start_valid) begin
               state_d = StInit;
               rcon_d  = 8'h01;
               round_d = '0;
            end
         end
         StInit: begin
            state_d = StSub;
            rcon_d  = xtime(rcon_q);
            round_d = 4'd1;
            wait_d  = '0;
         end
         StSub: begin
            wait_d = wait_q + CntW'(1);
            if (wait_q == WaitMax) begin
               state_d = StUpd;
            end
         end
         StUpd: begin
            if (round_q < LastRound) begin
               state_d = StSub;
               rcon_d  = xtime(rcon_q);
               round_d = round_q + 4'd1;
               wait_d  = '0;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (ctrl_io.i_out_ready) begin
               state_d = StIdle;
               round_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Moore outputs decoded from registered state only
   always_comb begin
      ctrl_io.o_state_load = 1'b0;
      ctrl_io.o_state_en   = 1'b0;
      ctrl_io.o_key_en     = 1'b0;
      ctrl_io.o_last_round = 1'b0;
      ctrl_io.o_out_valid  = 1'b0;
      ctrl_io.o_busy       = (state_q != StIdle);
      ctrl_io.o_start_ready = (state_q == StIdle);
      ctrl_io.o_rcon       = rcon_q;
      ctrl_io.o_round      = round_q;
      unique case (state_q)
         StInit: begin
            ctrl_io.o_state_load = 1'b1;
            ctrl_io.o_key_en     = 1'b1;
         end
         StSub: begin
            ctrl_io.o_last_round = (round_q == LastRound);
         end
         StUpd: begin
            ctrl_io.o_state_en   = 1'b1;
            ctrl_io.o_key_en     = (round_q < LastRound);
            ctrl_io.o_last_round = (round_q == LastRound);
         end
         StDone: begin
            ctrl_io.o_out_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
